// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
//
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock. It accepts
// one operation, spends N = WIDTH/CHUNK cycles rippling the carry through the
// chunks, and then holds the result until the consumer takes it.
// WIDTH must be an integer multiple of CHUNK.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request (sampled only while in_ready=1)
//   in_ready   block is idle and can accept operands
//   a, b       operands
//   cin        carry-in for add; ignored in subtract mode
//   mode       0 = a+b+cin, 1 = a-b
//   out_valid  result available (sum/cout/ovf valid only while high)
//   out_ready  consumer takes the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;          // already inverted for subtract
    logic [WIDTH-1:0] sum_work_r;   // partial result built slice by slice
    logic             carry_r;
    logic [KW-1:0]    k_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] next_sum_s;

    // Current chunk add and the partial result with this cycle's slice merged in.
    always_comb begin
        a_chunk_s   = a_r[int'(k_r) * CHUNK +: CHUNK];
        b_chunk_s   = b_r[int'(k_r) * CHUNK +: CHUNK];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        next_sum_s  = sum_work_r;
        next_sum_s[int'(k_r) * CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            sum        <= {WIDTH{1'b0}};
            cout       <= 1'b0;
            ovf        <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            sum_work_r <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            k_r        <= {KW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        // Subtract is a + ~b + 1: the +1 rides in as the first carry.
                        if (mode) begin
                            b_r     <= ~b;
                            carry_r <= 1'b1;
                        end else begin
                            b_r     <= b;
                            carry_r <= cin;
                        end
                        k_r      <= {KW{1'b0}};
                        state_r  <= CALC;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    sum_work_r <= next_sum_s;
                    carry_r    <= chunk_sum_s[CHUNK];
                    k_r        <= k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        // Outputs only change here, so they stay put outside HOLD.
                        state_r   <= HOLD;
                        out_valid <= 1'b1;
                        sum       <= next_sum_s;
                        cout      <= chunk_sum_s[CHUNK];
                        ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (next_sum_s[WIDTH-1] != a_r[WIDTH-1]);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    // Illegal encoding: recover to a clean idle state.
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_chunk_adder
//
// Self-checking bench for serial_chunk_adder (WIDTH=16, CHUNK=4). Directed
// corner cases followed by randomized operations, all compared against a
// plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_chunk_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum} from signed/unsigned integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic mmode);
        int          sa;
        int          sb;
        int          r;
        int unsigned ua;
        int unsigned ub;
        int unsigned u;
        logic        m_cout;
        logic        m_ovf;
        logic [W-1:0] m_sum;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'(ma);
        ub = int'(mb);
        if (mmode) begin
            r      = sa - sb;
            u      = ua - ub;
            m_cout = (ua >= ub);
        end else begin
            r      = sa + sb + int'(mcin);
            u      = ua + ub + int'(mcin);
            m_cout = (u >= 32'd65536);
        end
        m_sum = u[W-1:0];
        m_ovf = (r > 32767) || (r < -32768);
        return {m_ovf, m_cout, m_sum};
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom_range(0, 1));
        mode     = 1'($urandom_range(0, 1));
    endtask

    // One full operation: accept, latency check, hold with stability checks, release.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         input logic tmode, input int hold, input string tag);
        logic [W+1:0] e;
        int           budget;
        int           lat;
        e = model(ta, tb_v, tcin, tmode);
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check_val({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        mode     = tmode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        // Garbage on the inputs during CALC must be ignored.
        do begin
            scramble_inputs();
            if (lat == 0) check_val({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        check_val({tag, "_latency"}, 32'(lat), 32'(N));
        for (int h = 0; h < hold; h++) begin
            check_val({tag, "_hold_sum"}, 32'(sum), 32'(e[W-1:0]));
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            scramble_inputs();
            @(posedge clk); #1;
        end
        check_val({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
        check_val({tag, "_cout"}, 32'(cout), 32'(e[W]));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_released_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_released_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_idle_sum_kept"}, 32'(sum), 32'(e[W-1:0]));
    endtask

    // Main stimulus sequence.
    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        mode      = 1'b0;
        #12;
        check_val("reset_in_ready", 32'(in_ready), 32'd1);
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_sum", 32'(sum), 32'd0);
        check_val("reset_cout", 32'(cout), 32'd0);
        check_val("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1,  "add_small");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0,  "add_wrap");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2,  "add_all_ones_cin");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0,  "add_pos_ovf");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1,  "sub_neg_ovf");
        do_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0,  "sub_borrow");
        do_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0,  "sub_min");
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 10, "hold_10");

        // Reset during the second CALC cycle abandons the operation.
        a        = 16'h0001;
        b        = 16'h0001;
        cin      = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midreset_out_valid", 32'(out_valid), 32'd0);
        check_val("midreset_in_ready", 32'(in_ready), 32'd1);
        check_val("midreset_sum", 32'(sum), 32'd0);
        check_val("midreset_cout", 32'(cout), 32'd0);
        check_val("midreset_ovf", 32'(ovf), 32'd0);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check_val("midreset_no_result", 32'(seen), 32'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 2, "after_reset");

        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
